systemizer_ctrl: RTL and testbench
==================================

SYSTEMIZER_CTRL -- requirements
Module: systemizer_ctrl

Interface
REQ-001 SHALL have parameter N, default 20: matrix word width in elements, as used by the systemizer.
REQ-002 SHALL have parameter M, default 1: bits per element; the data width is DW = N*M.
REQ-003 SHALL have parameters L, default 200, and K, default 400: matrix rows and columns; W = L*K/N words, and AW = CLOG2(W).
REQ-004 SHALL have parameter MAX_RETRY, default 7: the maximum number of regenerations after a systemization fail.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port req_start, input, 1 bit: one-cycle request to begin a key attempt.
REQ-008 SHALL have ports mat_valid (in, 1), mat_data (in, DW) and mat_ready (out, 1): the incoming matrix word stream.
REQ-009 SHALL have port regen, output, 1 bit: one-cycle pulse requesting a fresh matrix from the source.
REQ-010 SHALL have ports sys_start (out, 1), sys_done (in, 1) and sys_fail (in, 1): the systemizer control handshake.
REQ-011 SHALL have ports sys_wr_en (out, 1), sys_wr_addr (out, AW) and sys_data_in (out, DW): the systemizer memory write port.
REQ-012 SHALL have ports sys_rd_en (out, 1), sys_rd_addr (out, AW) and sys_data_out (in, DW): the systemizer memory read port, with 1-cycle read latency.
REQ-013 SHALL have ports pk_valid (out, 1), pk_data (out, DW) and pk_ready (in, 1): the result word stream.
REQ-014 SHALL have outputs busy (1), done (1), error (1) and retry_cnt (CLOG2(MAX_RETRY+1)).

Function
REQ-015 SHALL implement the states IDLE, LOAD, START, WAIT, DRAIN, FINISH and ERROR.
REQ-016 In IDLE, FINISH or ERROR, req_start SHALL clear retry_cnt, done and error, and move to LOAD; while busy, req_start SHALL be ignored.
REQ-017 In LOAD, mat_ready SHALL be 1, and each mat_valid&&mat_ready cycle SHALL drive sys_wr_en=1 with sys_data_in=mat_data and sys_wr_addr=word counter in the same cycle.
REQ-018 The LOAD word counter SHALL start at 0 and increment per accepted word; acceptance of word W-1 SHALL move to START, and the counter SHALL never wrap.
REQ-019 START SHALL drive sys_start=1 for exactly one cycle and then enter WAIT.
REQ-020 In WAIT, sys_fail=1 SHALL take priority over a simultaneous sys_done=1.
REQ-021 In WAIT, sys_done=1 with sys_fail=0 SHALL enter DRAIN.
REQ-022 On fail with retry_cnt<MAX_RETRY, the block SHALL pulse regen for one cycle, increment retry_cnt and return to LOAD with the counter at 0.
REQ-023 On fail with retry_cnt==MAX_RETRY, the block SHALL enter ERROR with error=1.
REQ-024 sys_done and sys_fail SHALL be ignored outside WAIT.
REQ-025 DRAIN SHALL read addresses 0..W-1 in order through a 2-entry output buffer.
REQ-026 A DRAIN read SHALL issue only when occupancy plus in-flight reads < 2, so no word is lost under pk_ready=0.
REQ-027 pk_valid SHALL be 1 when the buffer is non-empty, and pk_data SHALL equal the head word and stay stable while pk_valid&&!pk_ready.
REQ-028 The DRAIN-to-FINISH transition SHALL occur after the handshake of word W-1; FINISH SHALL hold done=1.
REQ-029 busy SHALL be 1 in LOAD, START, WAIT and DRAIN, and 0 otherwise.
REQ-030 With pk_ready held at 1, DRAIN SHALL deliver one word per cycle after a 2-cycle initial latency.
REQ-031 The arithmetic rules SHALL be: counters AW+1 bits, with comparisons against W-1 only.

Reset
REQ-032 While rst=0, the state SHALL be IDLE, all counters and the buffer SHALL be cleared, and every output SHALL be 0 (pk_data 0).
REQ-033 An assertion of rst mid-LOAD, mid-WAIT or mid-DRAIN SHALL abort immediately, with no pulse on sys_start, regen or done after release.

Structure
REQ-034 A shared package SHALL hold the state enumeration, and the W/AW and retry-width derivations as functions of N, L, K and MAX_RETRY.
REQ-035 The 2-entry output buffer SHALL be one sub-module, pk_skid_fifo, parameterised by DW, with valid/ready on both sides.

Verification
REQ-036 With N=4, M=1, L=8, K=16 (W=32), stream 32 words with a passing systemizer model -> sys_wr_addr 0..31, one sys_start pulse, 32 pk words in order, done=1, retry_cnt=0.
REQ-037 With fail on the first two attempts -> two regen pulses, three LOAD passes of 32 writes, retry_cnt=2, done=1.
REQ-038 With MAX_RETRY=1 and always-fail -> two attempts, one regen, error=1, done=0, busy=0.
REQ-039 sys_done and sys_fail asserted in the same WAIT cycle -> treated as fail (regen pulse), no DRAIN.
REQ-040 During DRAIN, hold pk_ready=0 for 10 cycles, then toggle it -> pk_data stable while stalled, all 32 words delivered exactly once in order, and at most 2 reads outstanding plus buffered.
REQ-041 Assert rst at LOAD word 17, then issue req_start -> outputs 0 during reset, and a fresh LOAD restarting at address 0.

Source files
------------

// File: rtl/systemizer_ctrl_pkg.sv
// Shared types and size derivations for the systemizer controller.
package systemizer_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT, DRAIN, FINISH, ERROR
  } state_t;

  // Ceiling log2, never narrower than one bit so single-value ranges still get a port.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int words_f(input int n, input int l, input int k);
    return (l * k) / n;
  endfunction

  function automatic int addr_w_f(input int n, input int l, input int k);
    return clog2_min1(words_f(n, l, k));
  endfunction

  function automatic int retry_w_f(input int max_retry);
    return clog2_min1(max_retry + 1);
  endfunction

endpackage

// File: rtl/pk_skid_fifo.sv
// Two-entry output buffer with valid/ready on both sides; data registers reset to zero.
module pk_skid_fifo #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [1:0]    level
);

  logic [DW-1:0] mem [2];
  logic          head;
  logic          tail;
  logic [1:0]    cnt;
  logic          push;
  logic          pop;

  // A full buffer still accepts when the head leaves in the same cycle.
  assign in_ready  = (cnt != 2'd2) || out_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[head];
  assign level     = cnt;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= in_data;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/systemizer_ctrl.sv
// Controller that loads a matrix into the systemizer, retries on failure and drains the result.
module systemizer_ctrl
  import systemizer_ctrl_pkg::*;
#(
  parameter  int N         = 20,
  parameter  int M         = 1,
  parameter  int L         = 200,
  parameter  int K         = 400,
  parameter  int MAX_RETRY = 7,
  localparam int DW        = N * M,
  localparam int W         = words_f(N, L, K),
  localparam int AW        = addr_w_f(N, L, K),
  localparam int RW        = retry_w_f(MAX_RETRY)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_start,
  input  logic          mat_valid,
  input  logic [DW-1:0] mat_data,
  output logic          mat_ready,
  output logic          regen,
  output logic          sys_start,
  input  logic          sys_done,
  input  logic          sys_fail,
  output logic          sys_wr_en,
  output logic [AW-1:0] sys_wr_addr,
  output logic [DW-1:0] sys_data_in,
  output logic          sys_rd_en,
  output logic [AW-1:0] sys_rd_addr,
  input  logic [DW-1:0] sys_data_out,
  output logic          pk_valid,
  output logic [DW-1:0] pk_data,
  input  logic          pk_ready,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [RW-1:0] retry_cnt
);

  localparam logic [AW:0]   LAST = (AW + 1)'(W - 1);
  localparam logic [AW:0]   ONE  = (AW + 1)'(1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  state_t        state, state_nx;
  logic [AW:0]   wr_cnt, rd_cnt, pk_cnt;
  logic          rd_fin, rd_inflight;
  logic [RW-1:0] retry_q;
  logic          fifo_in_ready;
  logic [1:0]    fifo_level;
  logic          accept, pop, room, issue, launch;

  assign launch = req_start && (state == IDLE || state == FINISH || state == ERROR);
  assign accept = (state == LOAD) && mat_valid;
  assign pop    = pk_valid && pk_ready;

  // Buffered plus in-flight words, after this cycle's pop, must stay below two.
  assign room  = rd_inflight ? ((fifo_level == 2'd0) || (fifo_level == 2'd1 && pop))
                             : fifo_in_ready;
  assign issue = (state == DRAIN) && !rd_fin && room;

  assign mat_ready   = (state == LOAD);
  assign sys_wr_en   = accept;
  assign sys_wr_addr = wr_cnt[AW-1:0];
  assign sys_data_in = accept ? mat_data : '0;
  assign sys_start   = (state == START);
  assign regen       = (state == WAIT) && sys_fail && (retry_q < RMAX);
  assign sys_rd_en   = issue;
  assign sys_rd_addr = rd_cnt[AW-1:0];
  assign busy        = (state == LOAD) || (state == START) || (state == WAIT) || (state == DRAIN);
  assign done        = (state == FINISH);
  assign error       = (state == ERROR);
  assign retry_cnt   = retry_q;

  pk_skid_fifo #(.DW(DW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_inflight),
    .in_data   (sys_data_out),
    .in_ready  (fifo_in_ready),
    .out_valid (pk_valid),
    .out_data  (pk_data),
    .out_ready (pk_ready),
    .level     (fifo_level)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FINISH, ERROR: if (launch) state_nx = LOAD;
      LOAD:   if (accept && wr_cnt == LAST) state_nx = START;
      START:  state_nx = WAIT;
      WAIT: begin
        if (sys_fail)      state_nx = (retry_q < RMAX) ? LOAD : ERROR;
        else if (sys_done) state_nx = DRAIN;
      end
      DRAIN:  if (pop && pk_cnt == LAST) state_nx = FINISH;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      pk_cnt      <= '0;
      rd_fin      <= 1'b0;
      rd_inflight <= 1'b0;
      retry_q     <= '0;
    end else begin
      state       <= state_nx;
      rd_inflight <= issue;
      if (state != LOAD)   wr_cnt <= '0;
      else if (accept)     wr_cnt <= wr_cnt + ONE;
      if (state != DRAIN) begin
        rd_cnt <= '0;
        pk_cnt <= '0;
        rd_fin <= 1'b0;
      end else begin
        if (issue) begin
          rd_cnt <= rd_cnt + ONE;
          if (rd_cnt == LAST) rd_fin <= 1'b1;
        end
        if (pop) pk_cnt <= pk_cnt + ONE;
      end
      if (launch)     retry_q <= '0;
      else if (regen) retry_q <= retry_q + RW'(1);
    end
  end

endmodule

// File: tb/tb_systemizer_ctrl.sv
// Bench for systemizer_ctrl: scenario table with a systemizer memory model and a pk scoreboard.
module tb_systemizer_ctrl;
  localparam int N = 4, M = 1, L = 8, K = 16, W = 32, DW = 4, AW = 5, RW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          req_start = 1'b0, mat_valid = 1'b0, sys_done = 1'b0, sys_fail = 1'b0, pk_ready = 1'b0;
  logic [DW-1:0] mat_data = '0;
  logic          mat_ready, regen, sys_start, sys_wr_en, sys_rd_en, pk_valid, busy, done, error;
  logic [DW-1:0] sys_data_in, sys_data_out, pk_data;
  logic [AW-1:0] sys_wr_addr, sys_rd_addr;
  logic [RW-1:0] retry_cnt;

  logic          req_start1 = 1'b0, mat_valid1 = 1'b0, sys_done1 = 1'b0, sys_fail1 = 1'b0, pk_ready1 = 1'b0;
  logic [DW-1:0] mat_data1 = 4'h5, sys_data_out1 = '0;
  logic          mat_ready1, regen1, sys_start1, sys_wr_en1, sys_rd_en1, pk_valid1, busy1, done1, error1;
  logic [DW-1:0] sys_data_in1, pk_data1;
  logic [AW-1:0] sys_wr_addr1, sys_rd_addr1;
  logic [0:0]    retry_cnt1;

  systemizer_ctrl #(.N(N), .M(M), .L(L), .K(K), .MAX_RETRY(7)) dut (
    .clk(clk), .rst(rst), .req_start(req_start), .mat_valid(mat_valid), .mat_data(mat_data),
    .mat_ready(mat_ready), .regen(regen), .sys_start(sys_start), .sys_done(sys_done),
    .sys_fail(sys_fail), .sys_wr_en(sys_wr_en), .sys_wr_addr(sys_wr_addr),
    .sys_data_in(sys_data_in), .sys_rd_en(sys_rd_en), .sys_rd_addr(sys_rd_addr),
    .sys_data_out(sys_data_out), .pk_valid(pk_valid), .pk_data(pk_data), .pk_ready(pk_ready),
    .busy(busy), .done(done), .error(error), .retry_cnt(retry_cnt));

  systemizer_ctrl #(.N(N), .M(M), .L(L), .K(K), .MAX_RETRY(1)) dut1 (
    .clk(clk), .rst(rst), .req_start(req_start1), .mat_valid(mat_valid1), .mat_data(mat_data1),
    .mat_ready(mat_ready1), .regen(regen1), .sys_start(sys_start1), .sys_done(sys_done1),
    .sys_fail(sys_fail1), .sys_wr_en(sys_wr_en1), .sys_wr_addr(sys_wr_addr1),
    .sys_data_in(sys_data_in1), .sys_rd_en(sys_rd_en1), .sys_rd_addr(sys_rd_addr1),
    .sys_data_out(sys_data_out1), .pk_valid(pk_valid1), .pk_data(pk_data1), .pk_ready(pk_ready1),
    .busy(busy1), .done(done1), .error(error1), .retry_cnt(retry_cnt1));

  // Systemizer memory model: writes land at the edge, reads return one cycle later.
  logic [DW-1:0] mem [W];
  always @(posedge clk) begin
    if (sys_wr_en) mem[sys_wr_addr] <= sys_data_in;
    if (sys_rd_en) sys_data_out <= mem[sys_rd_addr];
  end

  int n_start, n_regen, n_wr, n_rd, n_hs, n_start1, n_regen1, n_wr1, n_rd1;
  always @(posedge clk) begin
    if (sys_start)  n_start  <= n_start + 1;
    if (regen)      n_regen  <= n_regen + 1;
    if (sys_wr_en)  n_wr     <= n_wr + 1;
    if (sys_start1) n_start1 <= n_start1 + 1;
    if (regen1)     n_regen1 <= n_regen1 + 1;
    if (sys_wr_en1) n_wr1    <= n_wr1 + 1;
    if (sys_rd_en1) n_rd1    <= n_rd1 + 1;
  end
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_rd <= 0;
      n_hs <= 0;
    end else begin
      if (sys_rd_en)           n_rd <= n_rd + 1;
      if (pk_valid && pk_ready) n_hs <= n_hs + 1;
    end
  end

  int total = 0, bad = 0;
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_val(input int a, input int i, input int s);
    return DW'(((i * 3 + a * 5 + s * 7) % 15) + 1);
  endfunction

  task automatic do_load(input int a, input int s, input bit noise, input int stop_at);
    int i = 0;
    int guard = 0;
    bit v;
    logic [DW-1:0] d;
    exp_q.delete();
    while (i < stop_at && guard < 500) begin
      @(negedge clk);
      req_start = noise && (i == 3);
      sys_done  = 1'b0;
      sys_fail  = noise && (i == 5);
      v = ($urandom_range(0, 3) != 0);
      d = word_val(a, i, s);
      mat_valid = v;
      mat_data  = d;
      #1;
      if (v) begin
        chk("mat_ready", mat_ready, 1);
        chk("wr_en", sys_wr_en, 1);
        chk("wr_addr", sys_wr_addr, i);
        chk("wr_data", sys_data_in, d);
        exp_q.push_back(d);
        i++;
      end else begin
        chk("wr_en_idle", sys_wr_en, 0);
      end
      guard++;
    end
    chk("load_words", i, stop_at);
    if (stop_at == W) begin
      @(negedge clk);
      mat_valid = 1'b0;
      sys_fail  = 1'b0;
      req_start = 1'b0;
      #1;
      chk("sys_start", sys_start, 1);
      chk("retry_at_start", retry_cnt, a);
      chk("done_while_busy", done, 0);
      chk("busy_start", busy, 1);
    end
  endtask

  task automatic respond(input bit fail, input bit both);
    @(negedge clk);
    #1;
    chk("sys_start_once", sys_start, 0);
    @(negedge clk);
    sys_fail = fail;
    sys_done = !fail || both;
    #1;
    chk("regen", regen, fail);
  endtask

  task automatic do_drain(input bit stall, input bit timing);
    int c = 0, got = 0, first = -1, lastc = -1;
    bit stalled = 1'b0;
    logic [DW-1:0] prev = '0, e;
    while (got < W && c < 500) begin
      @(negedge clk);
      sys_done = 1'b0;
      sys_fail = 1'b0;
      pk_ready = stall ? (c >= 10 && (c % 2) == 1) : 1'b1;
      #1;
      if (stalled) begin
        chk("stall_valid", pk_valid, 1);
        chk("stall_data", pk_data, prev);
      end
      chk("occupancy_le2", (n_rd - n_hs) <= 2, 1);
      if (pk_valid && pk_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        chk("pk_data", pk_data, e);
        if (first < 0) first = c;
        lastc = c;
        got++;
      end
      stalled = pk_valid && !pk_ready;
      prev = pk_data;
      c++;
    end
    chk("pk_count", got, W);
    chk("q_empty", exp_q.size(), 0);
    if (timing) begin
      chk("first_latency", first, 2);
      chk("last_word_cycle", lastc, W + 1);
    end
    @(negedge clk);
    pk_ready = 1'b0;
    #1;
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("pk_valid_after", pk_valid, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mat_ready"}, mat_ready, 0);
    chk({tag, "_regen"}, regen, 0);
    chk({tag, "_sys_start"}, sys_start, 0);
    chk({tag, "_wr_en"}, sys_wr_en, 0);
    chk({tag, "_wr_addr"}, sys_wr_addr, 0);
    chk({tag, "_data_in"}, sys_data_in, 0);
    chk({tag, "_rd_en"}, sys_rd_en, 0);
    chk({tag, "_rd_addr"}, sys_rd_addr, 0);
    chk({tag, "_pk_valid"}, pk_valid, 0);
    chk({tag, "_pk_data"}, pk_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_retry"}, retry_cnt, 0);
  endtask

  typedef struct {
    int fails;
    bit both;
    bit stall;
    bit noise;
    int exp_regen;
    int exp_retry;
  } vec_t;
  vec_t vecs [4];

  task automatic run_scenario(input int idx);
    vec_t v;
    int b_start, b_regen, b_wr, b_rd;
    v = vecs[idx];
    b_start = n_start; b_regen = n_regen; b_wr = n_wr; b_rd = n_rd;
    @(negedge clk);
    req_start = 1'b1;
    #1;
    chk("idle_busy", busy, 0);
    for (int a = 0; a <= v.fails; a++) begin
      do_load(a, idx, v.noise && a == 0, W);
      respond(a < v.fails, v.both);
    end
    do_drain(v.stall, !v.stall);
    chk("start_pulses", n_start - b_start, v.fails + 1);
    chk("regen_pulses", n_regen - b_regen, v.exp_regen);
    chk("writes", n_wr - b_wr, (v.fails + 1) * W);
    chk("reads", n_rd - b_rd, W);
    chk("retry_cnt", retry_cnt, v.exp_retry);
    chk("error", error, 0);
  endtask

  task automatic reset_mid(input bit in_drain);
    int b_start, b_regen;
    @(negedge clk);
    req_start = 1'b1;
    if (!in_drain) begin
      do_load(0, 9, 1'b0, W);
      respond(1'b1, 1'b0);
      do_load(1, 9, 1'b0, 17);
    end else begin
      do_load(0, 9, 1'b0, W);
      respond(1'b0, 1'b0);
      @(negedge clk);
      sys_done = 1'b0;
      pk_ready = 1'b0;
      repeat (4) @(negedge clk);
    end
    @(negedge clk);
    rst = 1'b0;
    mat_valid = 1'b1;
    mat_data = 4'hA;
    sys_done = 1'b0;
    sys_fail = 1'b0;
    #1;
    check_zero(in_drain ? "rst_drain" : "rst_load");
    b_start = n_start; b_regen = n_regen;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mat_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("post_rst_start", n_start - b_start, 0);
    chk("post_rst_regen", n_regen - b_regen, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    vecs[0] = '{fails: 0, both: 0, stall: 0, noise: 0, exp_regen: 0, exp_retry: 0};
    vecs[1] = '{fails: 2, both: 0, stall: 0, noise: 0, exp_regen: 2, exp_retry: 2};
    vecs[2] = '{fails: 1, both: 1, stall: 0, noise: 0, exp_regen: 1, exp_retry: 1};
    vecs[3] = '{fails: 0, both: 0, stall: 1, noise: 1, exp_regen: 0, exp_retry: 0};

    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    chk("reset_busy1", busy1, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int s = 0; s < 4; s++) run_scenario(s);

    reset_mid(1'b0);
    run_scenario(0);
    reset_mid(1'b1);
    run_scenario(0);

    // MAX_RETRY=1 instance with a systemizer that always fails (done raised alongside).
    @(negedge clk);
    req_start1 = 1'b1;
    mat_valid1 = 1'b1;
    sys_fail1  = 1'b1;
    sys_done1  = 1'b1;
    pk_ready1  = 1'b1;
    @(negedge clk);
    req_start1 = 1'b0;
    g = 0;
    while (!error1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    #1;
    chk("r1_error", error1, 1);
    chk("r1_done", done1, 0);
    chk("r1_busy", busy1, 0);
    chk("r1_regen", n_regen1, 1);
    chk("r1_starts", n_start1, 2);
    chk("r1_writes", n_wr1, 2 * W);
    chk("r1_reads", n_rd1, 0);
    chk("r1_retry", retry_cnt1, 1);
    @(negedge clk);
    req_start1 = 1'b1;
    sys_fail1  = 1'b0;
    sys_done1  = 1'b0;
    mat_valid1 = 1'b0;
    @(negedge clk);
    req_start1 = 1'b0;
    #1;
    chk("r1_error_clr", error1, 0);
    chk("r1_busy_again", busy1, 1);
    chk("r1_retry_clr", retry_cnt1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
